// File: rtl/day10_output_writer_if.sv
// 8-bit-or-wider AXI-Stream bundle used by the day10 reader and writer.
interface axi_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport transmitter (output tvalid, output tdata, output tlast, input tready);
  modport receiver    (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/day10_output_writer.sv
// Converts one binary result per start into decimal ASCII (MSD first, newline-terminated) on AXI-Stream.
// Optional macro DAY10_OUTPUT_SIGNED_EN: two's-complement input with a leading '-' byte.
module day10_output_writer #(
  parameter int unsigned RESULT_WIDTH   = 64,
  parameter int unsigned AXI_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [RESULT_WIDTH-1:0] value,
  input  logic                    last_output,
  output logic                    writer_ready,
  output logic                    write_complete,
  axi_stream_if.transmitter       data_out
);

  localparam int unsigned NUM_DIGITS = (RESULT_WIDTH * 30103) / 100000 + 1;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W      = $clog2(RESULT_WIDTH);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(RESULT_WIDTH - 1);

  if (AXI_DATA_WIDTH != 8) begin : g_bad_data_width
    $error("day10_output_writer: AXI_DATA_WIDTH must be 8");
  end
  if (RESULT_WIDTH < 4 || RESULT_WIDTH > 64) begin : g_bad_result_width
    $error("day10_output_writer: RESULT_WIDTH must be 4..64");
  end

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StConvert = 3'd1,
    StLocate  = 3'd2,
    StEmit    = 3'd3,
`ifdef DAY10_OUTPUT_SIGNED_EN
    StSign    = 3'd5,
`endif
    StNewline = 3'd4
  } state_t;

  state_t                  r_state;
  logic [RESULT_WIDTH-1:0] r_shift;
  logic [BCD_W-1:0]        r_bcd;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_last;
  logic                    r_write_complete;

  state_t                  w_state_nxt;
  logic [RESULT_WIDTH-1:0] w_shift_nxt;
  logic [BCD_W-1:0]        w_bcd_nxt;
  logic [CNT_W-1:0]        w_bit_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic                    w_last_nxt;
  logic                    w_write_complete_nxt;

  logic [BCD_W-1:0]        w_bcd_adj;
  logic [IDX_W-1:0]        w_msd_idx;
  logic [3:0]              w_digit;
  logic                    w_tvalid;
  logic [7:0]              w_tdata;
  logic                    w_tlast;

`ifdef DAY10_OUTPUT_SIGNED_EN
  logic                    r_neg;
  logic                    w_neg_nxt;
`endif

  // Double-dabble correction applied before every shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Highest nonzero digit wins; all-zero falls back to digit 0.
  always_comb begin
    w_msd_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) begin
        w_msd_idx = IDX_W'(i);
      end
    end
  end

  assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_state_nxt          = r_state;
    w_shift_nxt          = r_shift;
    w_bcd_nxt            = r_bcd;
    w_bit_cnt_nxt        = r_bit_cnt;
    w_idx_nxt            = r_idx;
    w_last_nxt           = r_last;
    w_write_complete_nxt = 1'b0;
    w_tvalid             = 1'b0;
    w_tdata              = 8'h00;
    w_tlast              = 1'b0;
`ifdef DAY10_OUTPUT_SIGNED_EN
    w_neg_nxt            = r_neg;
`endif

    case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt   = StConvert;
          w_last_nxt    = last_output;
          w_bcd_nxt     = '0;
          w_bit_cnt_nxt = '0;
          w_idx_nxt     = '0;
`ifdef DAY10_OUTPUT_SIGNED_EN
          w_neg_nxt     = value[RESULT_WIDTH-1];
          w_shift_nxt   = value[RESULT_WIDTH-1] ? (~value + 1'b1) : value;
`else
          w_shift_nxt   = value;
`endif
        end
      end

      StConvert: begin
        w_bcd_nxt     = BCD_W'({w_bcd_adj, r_shift[RESULT_WIDTH-1]});
        w_shift_nxt   = r_shift << 1;
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        if (r_bit_cnt == LastBit) begin
          w_state_nxt = StLocate;
        end
      end

      StLocate: begin
        w_idx_nxt   = w_msd_idx;
`ifdef DAY10_OUTPUT_SIGNED_EN
        w_state_nxt = r_neg ? StSign : StEmit;
`else
        w_state_nxt = StEmit;
`endif
      end

`ifdef DAY10_OUTPUT_SIGNED_EN
      StSign: begin
        w_tvalid = 1'b1;
        w_tdata  = 8'h2D;
        if (data_out.tready) begin
          w_state_nxt = StEmit;
        end
      end
`endif

      StEmit: begin
        w_tvalid = 1'b1;
        w_tdata  = 8'h30 + {4'h0, w_digit};
        if (data_out.tready) begin
          if (r_idx == '0) begin
            w_state_nxt = StNewline;
          end else begin
            w_idx_nxt = r_idx - 1'b1;
          end
        end
      end

      StNewline: begin
        w_tvalid = 1'b1;
        w_tdata  = 8'h0A;
        w_tlast  = r_last;
        if (data_out.tready) begin
          w_state_nxt          = StIdle;
          w_write_complete_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= StIdle;
      r_shift          <= '0;
      r_bcd            <= '0;
      r_bit_cnt        <= '0;
      r_idx            <= '0;
      r_last           <= 1'b0;
      r_write_complete <= 1'b0;
`ifdef DAY10_OUTPUT_SIGNED_EN
      r_neg            <= 1'b0;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_shift          <= w_shift_nxt;
      r_bcd            <= w_bcd_nxt;
      r_bit_cnt        <= w_bit_cnt_nxt;
      r_idx            <= w_idx_nxt;
      r_last           <= w_last_nxt;
      r_write_complete <= w_write_complete_nxt;
`ifdef DAY10_OUTPUT_SIGNED_EN
      r_neg            <= w_neg_nxt;
`endif
    end
  end

  // Stream outputs decode from the state register, so reset drops tvalid immediately.
  assign data_out.tvalid = w_tvalid;
  assign data_out.tdata  = w_tdata;
  assign data_out.tlast  = w_tlast;
  assign writer_ready    = (r_state == StIdle);
  assign write_complete  = r_write_complete;

endmodule

// File: tb/tb_day10_output_writer.sv
// Randomized self-checking bench for day10_output_writer against a decimal-printing reference model.
module tb_day10_output_writer;

  localparam int RW = 64;

  typedef logic [8:0] beat_t;  // {tlast, tdata}

  logic          clk;
  logic          rst;
  logic          start;
  logic [RW-1:0] value;
  logic          last_output;
  logic          writer_ready;
  logic          write_complete;

  axi_stream_if #(.DATA_WIDTH(8)) axis ();

  int n_checks = 0;
  int n_pass   = 0;

  day10_output_writer #(
    .RESULT_WIDTH   (RW),
    .AXI_DATA_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .value          (value),
    .last_output    (last_output),
    .writer_ready   (writer_ready),
    .write_complete (write_complete),
    .data_out       (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: print the number in decimal by repeated division.
  function automatic void model(input logic [RW-1:0] v, input logic l, output beat_t q[$]);
    logic [RW-1:0] mag;
    logic [7:0]    digs[$];
    q   = {};
    mag = v;
`ifdef DAY10_OUTPUT_SIGNED_EN
    if (v[RW-1]) begin
      mag = '0 - v;
      q.push_back({1'b0, 8'h2D});
    end
`endif
    do begin
      digs.push_front(8'h30 + 8'(mag % 10));
      mag = mag / 10;
    end while (mag != 0);
    foreach (digs[i]) q.push_back({1'b0, digs[i]});
    q.push_back({l, 8'h0A});
  endfunction

  function automatic bit same(input beat_t a[$], input beat_t b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(input beat_t q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%s%03h", (i == 0) ? "" : " ", q[i])};
    return s;
  endfunction

  task automatic issue(input logic [RW-1:0] v, input logic l);
    start       = 1'b1;
    value       = v;
    last_output = l;
    @(posedge clk);
    #1;
    start       = 1'b0;
    value       = {$urandom, $urandom};
    last_output = $urandom_range(1);
  endtask

  // Gathers handshaken beats until the newline; returns at the write_complete cycle (+1).
  task automatic collect(input int pct, output beat_t got[$], output int first_c,
                         output int last_c, output int stab_err, output bit wc_ok,
                         output bit timed_out);
    bit         prev_stall;
    logic [7:0] pd;
    logic       pl;
    got = {};
    first_c = -1; last_c = -1; stab_err = 0; wc_ok = 1'b0; timed_out = 1'b1;
    prev_stall = 1'b0; pd = '0; pl = 1'b0;
    axis.tready = ($urandom_range(99) < pct);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_stall && (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tlast !== pl))
        stab_err++;
      prev_stall = axis.tvalid && !axis.tready;
      pd = axis.tdata;
      pl = axis.tlast;
      if (axis.tvalid && axis.tready) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        got.push_back({axis.tlast, axis.tdata});
      end
      @(posedge clk);
      #1;
      if (last_c == c && got[got.size()-1][7:0] == 8'h0A) begin
        wc_ok     = write_complete && writer_ready;
        timed_out = 1'b0;
        break;
      end
      axis.tready = ($urandom_range(99) < pct);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (writer_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", writer_ready);
    else n_pass++;
    n_checks++;
    if (write_complete !== 1'b0) $display("FAIL reset_wc: got %b expected 0", write_complete);
    else n_pass++;
    n_checks++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 8'h00 || axis.tlast !== 1'b0)
      $display("FAIL reset_axis: got v=%b d=%h l=%b expected v=0 d=00 l=0",
               axis.tvalid, axis.tdata, axis.tlast);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [RW-1:0] vals[2];
    logic          lasts[2];
    beat_t got[$], exp[$];
    int fc, lc, st;
    bit wc, to;
    vals[0] = '0;          lasts[0] = 1'b1;
    vals[1] = RW'(1234);   lasts[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model(vals[k], lasts[k], exp);
      issue(vals[k], lasts[k]);
      n_checks++;
      if (writer_ready !== 1'b0) $display("FAIL basic%0d_busy: got ready=%b expected 0", k, writer_ready);
      else n_pass++;
      collect(100, got, fc, lc, st, wc, to);
      n_checks++;
      if (to || !same(got, exp))
        $display("FAIL basic%0d_bytes: got [%s] expected [%s]", k, fmt(got), fmt(exp));
      else n_pass++;
      n_checks++;
      if (fc != RW + 1 || lc - fc != exp.size() - 1)
        $display("FAIL basic%0d_timing: got first=%0d last=%0d expected first=%0d last=%0d",
                 k, fc, lc, RW + 1, RW + exp.size());
      else n_pass++;
      n_checks++;
      if (!wc) $display("FAIL basic%0d_wc: got wc/ready low expected both high", k);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (write_complete !== 1'b0)
        $display("FAIL basic%0d_wc_pulse: got %b one cycle later expected 0", k, write_complete);
      else n_pass++;
    end
  endtask

  task automatic test_max_stall();
    beat_t got[$], exp[$];
    int fc, lc, st;
    bit wc, to;
    logic [RW-1:0] v;
    v = '1;
`ifdef DAY10_OUTPUT_SIGNED_EN
    v = {1'b0, {(RW-1){1'b1}}};
`endif
    model(v, 1'b1, exp);
    issue(v, 1'b1);
    collect(50, got, fc, lc, st, wc, to);
    n_checks++;
    if (to || !same(got, exp))
      $display("FAIL max_bytes: got [%s] expected [%s]", fmt(got), fmt(exp));
    else n_pass++;
    n_checks++;
    if (st != 0) $display("FAIL max_stable: got %0d stall violations expected 0", st);
    else n_pass++;
    n_checks++;
    if (!wc) $display("FAIL max_wc: got wc/ready low expected both high");
    else n_pass++;
  endtask

  task automatic test_random();
    beat_t got[$], exp[$];
    int fc, lc, st;
    bit wc, to;
    logic [RW-1:0] v;
    logic l;
    for (int k = 0; k < 12; k++) begin
      v = {$urandom, $urandom} >> $urandom_range(RW - 1);
      l = $urandom_range(1);
      model(v, l, exp);
      issue(v, l);
      collect(30 + $urandom_range(70), got, fc, lc, st, wc, to);
      n_checks++;
      if (to || !same(got, exp) || st != 0 || !wc)
        $display("FAIL rand%0d: got [%s] stall=%0d wc=%b expected [%s] stall=0 wc=1",
                 k, fmt(got), st, wc, fmt(exp));
      else n_pass++;
    end
  endtask

  task automatic test_busy_start();
    beat_t got[$], exp[$];
    int fc, lc, st;
    bit wc, to;
    issue(RW'(90), 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    value = RW'(7);
    @(posedge clk);
    #1;
    start = 1'b0;
    model(RW'(90), 1'b0, exp);
    collect(100, got, fc, lc, st, wc, to);
    n_checks++;
    if (to || !same(got, exp))
      $display("FAIL busy_ignored: got [%s] expected [%s]", fmt(got), fmt(exp));
    else n_pass++;
    issue(RW'(7), 1'b1);
    model(RW'(7), 1'b1, exp);
    collect(100, got, fc, lc, st, wc, to);
    n_checks++;
    if (to || !same(got, exp) || fc != RW + 1)
      $display("FAIL busy_b2b: got [%s] first=%0d expected [%s] first=%0d",
               fmt(got), fc, fmt(exp), RW + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    beat_t got[$], exp[$];
    int fc, lc, st, seen;
    bit wc, to, found;
    found = 1'b0;
    seen  = 0;
    issue(RW'(56789), 1'b0);
    axis.tready = 1'b1;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (axis.tvalid && axis.tdata == 8'h37) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL rstmid_reach: got no third digit expected 37");
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (axis.tvalid !== 1'b0 || writer_ready !== 1'b1)
      $display("FAIL rstmid_async: got tvalid=%b ready=%b expected 0/1", axis.tvalid, writer_ready);
    else n_pass++;
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (axis.tvalid) seen++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (seen != 0) $display("FAIL rstmid_quiet: got %0d valid cycles expected 0", seen);
    else n_pass++;
    model(RW'(5), 1'b0, exp);
    issue(RW'(5), 1'b0);
    collect(100, got, fc, lc, st, wc, to);
    n_checks++;
    if (to || !same(got, exp) || fc != RW + 1)
      $display("FAIL rstmid_next: got [%s] first=%0d expected [%s] first=%0d",
               fmt(got), fc, fmt(exp), RW + 1);
    else n_pass++;
  endtask

`ifdef DAY10_OUTPUT_SIGNED_EN
  task automatic test_signed();
    logic [RW-1:0] vals[3];
    beat_t got[$], exp[$];
    int fc, lc, st;
    bit wc, to;
    vals[0] = '0 - RW'(5);
    vals[1] = {1'b1, {(RW-1){1'b0}}};
    vals[2] = {1'b0, {(RW-1){1'b1}}};
    for (int k = 0; k < 3; k++) begin
      model(vals[k], 1'b1, exp);
      issue(vals[k], 1'b1);
      collect(60, got, fc, lc, st, wc, to);
      n_checks++;
      if (to || !same(got, exp) || st != 0)
        $display("FAIL signed%0d: got [%s] stall=%0d expected [%s]", k, fmt(got), st, fmt(exp));
      else n_pass++;
    end
    model(vals[0], 1'b0, exp);
    issue(vals[0], 1'b0);
    collect(100, got, fc, lc, st, wc, to);
    n_checks++;
    if (to || fc != RW + 1) $display("FAIL signed_latency: got first=%0d expected %0d", fc, RW + 1);
    else n_pass++;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    value       = '0;
    last_output = 1'b0;
    axis.tready = 1'b0;
    test_reset();
    test_basic();
    test_max_stall();
    test_random();
    test_busy_start();
    test_reset_mid();
`ifdef DAY10_OUTPUT_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
